// File: rtl/jesd_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// jesd_rx_link_ctrl
//
// Link bring-up and supervision FSM for a JESD204B receiver. It drives SYNC~
// through code-group sync (CGS), the initial lane alignment sequence (ILAS)
// and DATA. It requests resynchronisation when sync is lost, when ILAS takes
// too long, or when there are too many lane errors within one LMFC period.
// Everything runs in the RX core clock domain. All lane status inputs are
// assumed to be synchronised into this domain already.
//
// Ports:
//   clk_i            core clock
//   rst_i            synchronous active-high reset
//   enable_i         link enable; low forces IDLE
//   lane_cgs_i       per-lane code-group sync achieved (level)
//   lane_ilas_done_i per-lane ILAS complete (level)
//   lane_err_i       per-lane disparity/not-in-table error (1-cycle pulse)
//   lmfc_edge_i      LMFC boundary pulse
//   sync_n_o         JESD SYNC~, active-low (high only in ILAS and DATA)
//   link_up_o        high only in DATA
//   state_o          current state: IDLE=0 CGS=1 WAIT_LMFC=2 ILAS=3
//                    DATA=4 RESYNC=5
//   resync_cnt_o     saturating count of RESYNC entries
// ---------------------------------------------------------------------------
module jesd_rx_link_ctrl #(
  parameter int LANES          = 4,
  parameter int CGS_MIN_CYCLES = 8,
  parameter int ILAS_TIMEOUT   = 1024,
  parameter int ERR_THRESH     = 4,
  parameter int RESYNC_HOLD    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [LANES-1:0] lane_cgs_i,
  input  logic [LANES-1:0] lane_ilas_done_i,
  input  logic [LANES-1:0] lane_err_i,
  input  logic             lmfc_edge_i,
  output logic             sync_n_o,
  output logic             link_up_o,
  output logic [2:0]       state_o,
  output logic [7:0]       resync_cnt_o
);

  localparam int CGS_W  = (CGS_MIN_CYCLES > 1) ? $clog2(CGS_MIN_CYCLES) : 1;
  localparam int ILAS_W = (ILAS_TIMEOUT   > 1) ? $clog2(ILAS_TIMEOUT)   : 1;
  localparam int ERR_W  = (ERR_THRESH     > 1) ? $clog2(ERR_THRESH)     : 1;
  localparam int HOLD_W = (RESYNC_HOLD    > 1) ? $clog2(RESYNC_HOLD)    : 1;
  // One extra bit so the updated error count can reach ERR_THRESH itself
  // before it is compared.
  localparam int ERR_SW = ERR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CGS       = 3'd1,
    ST_WAIT_LMFC = 3'd2,
    ST_ILAS      = 3'd3,
    ST_DATA      = 3'd4,
    ST_RESYNC    = 3'd5
  } state_t;

  state_t             state_reg, state_next;
  logic [CGS_W-1:0]   cgs_cnt_reg, cgs_cnt_next;
  logic [ILAS_W-1:0]  ilas_timer_reg, ilas_timer_next;
  logic [ERR_W-1:0]   err_cnt_reg, err_cnt_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [7:0]         resync_cnt_reg;
  logic               sync_n_reg;
  logic               link_up_reg;

  logic               all_cgs;
  logic               all_ilas;
  logic               any_err;
  logic [ERR_SW-1:0]  err_sum;
  logic               enter_resync;

  assign all_cgs  = &lane_cgs_i;
  assign all_ilas = &lane_ilas_done_i;
  // Several lanes erroring in the same cycle count as a single error cycle.
  assign any_err  = |lane_err_i;

  // Updated error count: an LMFC edge starts a new window, and the current
  // cycle's error belongs to that new window.
  always_comb begin
    if (lmfc_edge_i) begin
      err_sum = ERR_SW'(any_err);
    end else begin
      err_sum = {1'b0, err_cnt_reg} + ERR_SW'(any_err);
    end
  end

  // Next-state and counter update. Each counter is cleared when its state is
  // left, so it always starts from 0 on the next entry.
  always_comb begin
    state_next      = state_reg;
    cgs_cnt_next    = cgs_cnt_reg;
    ilas_timer_next = ilas_timer_reg;
    err_cnt_next    = err_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;

    if (!enable_i) begin
      state_next      = ST_IDLE;
      cgs_cnt_next    = '0;
      ilas_timer_next = '0;
      err_cnt_next    = '0;
      hold_cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_CGS;
        end

        ST_CGS: begin
          if (all_cgs) begin
            if (cgs_cnt_reg == CGS_W'(CGS_MIN_CYCLES - 1)) begin
              state_next   = ST_WAIT_LMFC;
              cgs_cnt_next = '0;
            end else begin
              cgs_cnt_next = cgs_cnt_reg + CGS_W'(1);
            end
          end else begin
            cgs_cnt_next = '0;
          end
        end

        ST_WAIT_LMFC: begin
          // Losing sync takes priority over the LMFC edge, so SYNC~ is only
          // released on an LMFC boundary with all lanes still in sync.
          if (!all_cgs) begin
            state_next = ST_CGS;
          end else if (lmfc_edge_i) begin
            state_next = ST_ILAS;
          end
        end

        ST_ILAS: begin
          // ILAS completion wins over a timeout in the same cycle.
          if (all_ilas) begin
            state_next      = ST_DATA;
            ilas_timer_next = '0;
          end else if (!all_cgs ||
                       ilas_timer_reg == ILAS_W'(ILAS_TIMEOUT - 1)) begin
            state_next      = ST_RESYNC;
            ilas_timer_next = '0;
          end else begin
            ilas_timer_next = ilas_timer_reg + ILAS_W'(1);
          end
        end

        ST_DATA: begin
          if (err_sum >= ERR_SW'(ERR_THRESH) || !all_cgs) begin
            state_next   = ST_RESYNC;
            err_cnt_next = '0;
          end else begin
            err_cnt_next = err_sum[ERR_W-1:0];
          end
        end

        ST_RESYNC: begin
          if (hold_cnt_reg == HOLD_W'(RESYNC_HOLD - 1)) begin
            state_next    = ST_CGS;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end

        default: begin
          state_next      = ST_IDLE;
          cgs_cnt_next    = '0;
          ilas_timer_next = '0;
          err_cnt_next    = '0;
          hold_cnt_next   = '0;
        end
      endcase
    end
  end

  assign enter_resync = (state_next == ST_RESYNC) && (state_reg != ST_RESYNC);

  // State, counters and Moore outputs. Outputs are registered from the next
  // state so they change on the same edge as the state they decode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      cgs_cnt_reg    <= '0;
      ilas_timer_reg <= '0;
      err_cnt_reg    <= '0;
      hold_cnt_reg   <= '0;
      resync_cnt_reg <= '0;
      sync_n_reg     <= 1'b0;
      link_up_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cgs_cnt_reg    <= cgs_cnt_next;
      ilas_timer_reg <= ilas_timer_next;
      err_cnt_reg    <= err_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      sync_n_reg     <= (state_next == ST_ILAS) || (state_next == ST_DATA);
      link_up_reg    <= (state_next == ST_DATA);
      if (enter_resync && resync_cnt_reg != 8'hFF) begin
        resync_cnt_reg <= resync_cnt_reg + 8'd1;
      end
    end
  end

  assign sync_n_o     = sync_n_reg;
  assign link_up_o    = link_up_reg;
  assign state_o      = state_reg;
  assign resync_cnt_o = resync_cnt_reg;

endmodule

// File: tb/tb_jesd_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jesd_rx_link_ctrl
//
// Directed bench for jesd_rx_link_ctrl with CGS_MIN_CYCLES=8 and
// ILAS_TIMEOUT=64 (other parameters at their defaults). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point, so each
// tick() applies exactly one clock edge to the inputs set before it.
// ---------------------------------------------------------------------------
module tb_jesd_rx_link_ctrl;

  localparam int LANES = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CGS    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ILAS   = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_RESYNC = 3'd5;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [LANES-1:0] lane_cgs;
  logic [LANES-1:0] lane_ilas_done;
  logic [LANES-1:0] lane_err;
  logic             lmfc_edge;
  logic             sync_n;
  logic             link_up;
  logic [2:0]       state;
  logic [7:0]       resync_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_resync = 0;

  jesd_rx_link_ctrl #(
    .LANES          (LANES),
    .CGS_MIN_CYCLES (8),
    .ILAS_TIMEOUT   (64),
    .ERR_THRESH     (4),
    .RESYNC_HOLD    (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (enable),
    .lane_cgs_i       (lane_cgs),
    .lane_ilas_done_i (lane_ilas_done),
    .lane_err_i       (lane_err),
    .lmfc_edge_i      (lmfc_edge),
    .sync_n_o         (sync_n),
    .link_up_o        (link_up),
    .state_o          (state),
    .resync_cnt_o     (resync_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected values.
  task automatic check_all(input string tag, input logic [2:0] st,
                           input logic sn, input logic lu,
                           input logic [7:0] rc);
    check({tag, ".state"}, {5'd0, state}, {5'd0, st});
    check({tag, ".sync_n"}, {7'd0, sync_n}, {7'd0, sn});
    check({tag, ".link_up"}, {7'd0, link_up}, {7'd0, lu});
    check({tag, ".resync_cnt"}, resync_cnt, rc);
  endtask

  // From CGS with a cleared counter: 8 all-sync cycles then an LMFC edge.
  task automatic cgs_to_ilas(input string tag);
    lane_cgs = 4'hF;
    repeat (7) tick();
    check({tag, ".cgs7"}, {5'd0, state}, {5'd0, S_CGS});
    tick();
    check({tag, ".wait"}, {5'd0, state}, {5'd0, S_WAIT});
    lmfc_edge = 1'b1;
    tick();
    lmfc_edge = 1'b0;
    check({tag, ".ilas"}, {5'd0, state}, {5'd0, S_ILAS});
    check({tag, ".ilas_sync"}, {7'd0, sync_n}, 8'd1);
  endtask

  task automatic ilas_to_data(input string tag);
    lane_ilas_done = 4'hF;
    tick();
    lane_ilas_done = 4'h0;
    check_all({tag, ".data"}, S_DATA, 1'b1, 1'b1, 8'(exp_resync));
  endtask

  task automatic pulse_err(input logic [LANES-1:0] val);
    lane_err = val;
    tick();
    lane_err = '0;
  endtask

  // Sits in RESYNC: 15 more edges stay there with SYNC~ low, the 16th
  // returns to CGS.
  task automatic ride_resync(input string tag);
    repeat (15) tick();
    check_all({tag, ".hold15"}, S_RESYNC, 1'b0, 1'b0, 8'(exp_resync));
    tick();
    check({tag, ".back_cgs"}, {5'd0, state}, {5'd0, S_CGS});
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    lane_cgs = '0;
    lane_ilas_done = '0;
    lane_err = '0;
    lmfc_edge = 1'b0;

    // Reset state.
    tick();
    tick();
    check_all("reset", S_IDLE, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    tick();
    check("idle_no_enable", {5'd0, state}, {5'd0, S_IDLE});

    // Bring-up: 8 CGS cycles, LMFC edge 20 cycles after enable, ILAS done
    // 10 cycles after the LMFC edge.
    enable = 1'b1;
    lane_cgs = 4'hF;
    tick();
    check("enable_cgs", {5'd0, state}, {5'd0, S_CGS});
    repeat (7) tick();
    check("cgs_7", {5'd0, state}, {5'd0, S_CGS});
    tick();
    check_all("cgs_8", S_WAIT, 1'b0, 1'b0, 8'd0);
    repeat (11) tick();
    check_all("wait_lmfc", S_WAIT, 1'b0, 1'b0, 8'd0);
    lmfc_edge = 1'b1;
    tick();
    lmfc_edge = 1'b0;
    check_all("lmfc_ilas", S_ILAS, 1'b1, 1'b0, 8'd0);
    repeat (9) tick();
    check_all("ilas_wait", S_ILAS, 1'b1, 1'b0, 8'd0);
    ilas_to_data("bringup");

    // DATA: 3 error cycles per LMFC period (multi-lane errors count once).
    lmfc_edge = 1'b1;
    tick();
    lmfc_edge = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulse_err(4'hF);
      pulse_err(4'h3);
      tick();
      pulse_err(4'h8);
      lmfc_edge = 1'b1;
      tick();
      lmfc_edge = 1'b0;
      check_all("err3_stay", S_DATA, 1'b1, 1'b1, 8'd0);
    end

    // DATA: 4 error cycles in one period -> RESYNC.
    pulse_err(4'h1);
    pulse_err(4'h2);
    pulse_err(4'h4);
    check("err3_before4", {5'd0, state}, {5'd0, S_DATA});
    pulse_err(4'h8);
    exp_resync = 1;
    check_all("err4_resync", S_RESYNC, 1'b0, 1'b0, 8'd1);
    ride_resync("resync1");

    // DATA: 4th error coincides with loss of CGS -> one RESYNC entry.
    cgs_to_ilas("r2");
    ilas_to_data("r2");
    lmfc_edge = 1'b1;
    tick();
    lmfc_edge = 1'b0;
    pulse_err(4'h1);
    pulse_err(4'h1);
    pulse_err(4'h1);
    lane_cgs = 4'hE;
    pulse_err(4'h1);
    lane_cgs = 4'hF;
    exp_resync = 2;
    check_all("err_and_cgs", S_RESYNC, 1'b0, 1'b0, 8'd2);
    ride_resync("resync2");

    // WAIT_LMFC: loss of CGS beats a simultaneous LMFC edge.
    repeat (8) tick();
    check("wait_again", {5'd0, state}, {5'd0, S_WAIT});
    lane_cgs = 4'hE;
    lmfc_edge = 1'b1;
    tick();
    lmfc_edge = 1'b0;
    check_all("wait_drop", S_CGS, 1'b0, 1'b0, 8'd2);

    // CGS: 7 good cycles, lane 2 drops for one, then 8 more are required.
    lane_cgs = 4'hF;
    repeat (7) tick();
    lane_cgs = 4'hB;
    tick();
    check("cgs_glitch", {5'd0, state}, {5'd0, S_CGS});
    lane_cgs = 4'hF;
    repeat (7) tick();
    check("cgs_glitch_7", {5'd0, state}, {5'd0, S_CGS});
    tick();
    check("cgs_glitch_8", {5'd0, state}, {5'd0, S_WAIT});

    // ILAS timeout with lane 3 never finishing: 64 cycles then RESYNC.
    lmfc_edge = 1'b1;
    tick();
    lmfc_edge = 1'b0;
    lane_ilas_done = 4'h7;
    repeat (63) tick();
    check_all("ilas_63", S_ILAS, 1'b1, 1'b0, 8'd2);
    tick();
    exp_resync = 3;
    check_all("ilas_timeout", S_RESYNC, 1'b0, 1'b0, 8'd3);
    lane_ilas_done = 4'h0;
    ride_resync("resync3");

    // enable_i low mid-ILAS -> IDLE next cycle, resync count kept.
    cgs_to_ilas("en");
    repeat (3) tick();
    enable = 1'b0;
    tick();
    check_all("disable_ilas", S_IDLE, 1'b0, 1'b0, 8'd3);
    enable = 1'b1;
    tick();
    check("reenable", {5'd0, state}, {5'd0, S_CGS});

    // Repeated resyncs via CGS loss in ILAS; count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      lane_cgs = 4'hF;
      repeat (8) tick();
      lmfc_edge = 1'b1;
      tick();
      lmfc_edge = 1'b0;
      lane_cgs = 4'hE;
      tick();
      lane_cgs = 4'hF;
      if (exp_resync < 255) exp_resync++;
      check("sat_count", resync_cnt, 8'(exp_resync));
      repeat (16) tick();
    end
    check_all("sat_final", S_CGS, 1'b0, 1'b0, 8'd255);

    // Reset mid-DATA clears everything including the resync count.
    cgs_to_ilas("rst");
    ilas_to_data("rst");
    rst = 1'b1;
    tick();
    check_all("reset_data", S_IDLE, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
